// File: rtl/led_scan_mux.sv
// Multiplexed seven-segment scanner: per-digit PWM brightness, blanking and blinking.
// All outputs registered, one cycle behind the counter state; no backpressure, free-running scan.
module led_scan_mux #(
    parameter int NUM_DIGITS = 6,
    parameter int SEG_W      = 7,
    parameter int SCAN_DIV   = 5000,
    parameter int BLINK_DIV  = 25000000,
    parameter int BRIGHT_W   = 3,
    parameter int IDX_W      = $clog2(NUM_DIGITS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_en,
    input  logic [NUM_DIGITS*SEG_W-1:0] i_seg,
    input  logic [NUM_DIGITS-1:0]       i_dp,
    input  logic [NUM_DIGITS-1:0]       i_blank,
    input  logic [NUM_DIGITS-1:0]       i_blink,
    input  logic [BRIGHT_W-1:0]         i_bright,
    output logic [SEG_W-1:0]            o_seg,
    output logic                        o_seg_dp,
    output logic [NUM_DIGITS-1:0]       o_seg_enb,
    output logic [IDX_W-1:0]            o_digit_idx,
    output logic                        o_frame_tick
);

    localparam int PC_W = $clog2(SCAN_DIV);
    localparam int PW   = BRIGHT_W + 1 + $clog2(SCAN_DIV + 1);
    localparam int BC_W = $clog2(BLINK_DIV);

    logic [PC_W-1:0]     pcnt;
    logic [IDX_W-1:0]    idx;
    logic [BRIGHT_W-1:0] bright_q;
    logic [BC_W-1:0]     blink_cnt;
    logic                blink_ph;
    logic                tick_pend;

    logic                pcnt_last;
    logic                idx_last;
    logic [PW-1:0]       prod;
    logic [PW-1:0]       on_cycles;
    logic                pwm_on;
    logic [SEG_W-1:0]    seg_sel;
    logic                dp_sel;
    logic                blank_sel;
    logic                blink_sel;
    logic                lit;
    logic [NUM_DIGITS-1:0] enb_nxt;

    assign pcnt_last = (pcnt == PC_W'(SCAN_DIV - 1));
    assign idx_last  = (idx == IDX_W'(NUM_DIGITS - 1));

    // Full-width product so all-ones brightness yields exactly SCAN_DIV on-cycles.
    assign prod      = (PW'(bright_q) + PW'(1)) * PW'(SCAN_DIV);
    assign on_cycles = prod >> BRIGHT_W;
    assign pwm_on    = (PW'(pcnt) < on_cycles);

    always_comb begin
        seg_sel   = '0;
        dp_sel    = 1'b0;
        blank_sel = 1'b0;
        blink_sel = 1'b0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (idx == IDX_W'(d)) begin
                seg_sel   = i_seg[d*SEG_W +: SEG_W];
                dp_sel    = i_dp[d];
                blank_sel = i_blank[d];
                blink_sel = i_blink[d];
            end
        end
        lit     = i_en & pwm_on & ~blank_sel & ~(blink_sel & blink_ph);
        enb_nxt = '1;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (lit && (idx == IDX_W'(d))) begin
                enb_nxt[d] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt         <= '0;
            idx          <= '0;
            bright_q     <= '1;
            tick_pend    <= 1'b0;
            o_seg        <= '0;
            o_seg_dp     <= 1'b0;
            o_seg_enb    <= '1;
            o_digit_idx  <= '0;
            o_frame_tick <= 1'b0;
        end else begin
            o_seg_enb    <= enb_nxt;
            o_seg        <= lit ? seg_sel : '0;
            o_seg_dp     <= lit & dp_sel;
            o_digit_idx  <= i_en ? idx : '0;
            // Pend the tick one cycle so it lands with digit 0's first output.
            o_frame_tick <= tick_pend & i_en;
            tick_pend    <= i_en & pcnt_last & idx_last;

            if (!i_en) begin
                pcnt <= '0;
                idx  <= '0;
            end else if (pcnt_last) begin
                pcnt     <= '0;
                idx      <= idx_last ? '0 : idx + IDX_W'(1);
                bright_q <= i_bright;
            end else begin
                pcnt <= pcnt + PC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else if (blink_cnt == BC_W'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            blink_ph  <= ~blink_ph;
        end else begin
            blink_cnt <= blink_cnt + BC_W'(1);
        end
    end

endmodule

// File: tb/tb_led_scan_mux.sv
// Bench for led_scan_mux: elapsed-time reference model plus directed and random scenarios.
module tb_led_scan_mux;

    localparam int ND = 4;
    localparam int SW = 7;
    localparam int SD = 8;
    localparam int BD = 64;
    localparam int BW = 3;
    localparam int IW = 2;
    localparam int OW = ND + SW + 1 + IW + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_en;
    logic [ND*SW-1:0]  i_seg;
    logic [ND-1:0]     i_dp;
    logic [ND-1:0]     i_blank;
    logic [ND-1:0]     i_blink;
    logic [BW-1:0]     i_bright;
    logic [SW-1:0]     o_seg;
    logic              o_seg_dp;
    logic [ND-1:0]     o_seg_enb;
    logic [IW-1:0]     o_digit_idx;
    logic              o_frame_tick;

    led_scan_mux #(
        .NUM_DIGITS(ND), .SEG_W(SW), .SCAN_DIV(SD), .BLINK_DIV(BD), .BRIGHT_W(BW)
    ) dut (
        .clk(clk), .rst(rst), .i_en(i_en), .i_seg(i_seg), .i_dp(i_dp),
        .i_blank(i_blank), .i_blink(i_blink), .i_bright(i_bright),
        .o_seg(o_seg), .o_seg_dp(o_seg_dp), .o_seg_enb(o_seg_enb),
        .o_digit_idx(o_digit_idx), .o_frame_tick(o_frame_tick)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: elapsed scan time since the last (re)start, elapsed time since reset, latched brightness.
    int t_run;
    int t_rst;
    int bq;
    logic [ND-1:0] e_enb;
    logic [SW-1:0] e_seg;
    logic          e_dp;
    logic [IW-1:0] e_idx;
    logic          e_tick;
    logic          e_lit;

    logic [OW-1:0] obs;
    logic [OW-1:0] exp_v;
    assign obs   = {o_seg_enb, o_seg, o_seg_dp, o_digit_idx, o_frame_tick};
    assign exp_v = {e_enb, e_seg, e_dp, e_idx, e_tick};

    task automatic model_reset();
        t_run  = 0;
        t_rst  = 0;
        bq     = (1 << BW) - 1;
        e_enb  = '1;
        e_seg  = '0;
        e_dp   = 1'b0;
        e_idx  = '0;
        e_tick = 1'b0;
    endtask

    task automatic tick();
        int pos, dig, on, ph;
        pos   = t_run % SD;
        dig   = (t_run / SD) % ND;
        on    = ((bq + 1) * SD) >> BW;
        ph    = (t_rst / BD) % 2;
        e_lit = i_en && (pos < on) && !i_blank[dig] && !(i_blink[dig] && ph == 1);
        e_enb = '1;
        if (e_lit) e_enb[dig] = 1'b0;
        e_seg  = e_lit ? i_seg[dig*SW +: SW] : '0;
        e_dp   = e_lit ? i_dp[dig] : 1'b0;
        e_idx  = i_en ? IW'(dig) : '0;
        e_tick = i_en && pos == 0 && dig == 0 && t_run > 0;
        if (i_en) begin
            if (pos == SD - 1) bq = int'(i_bright);
            t_run++;
        end else begin
            t_run = 0;
        end
        t_rst++;
        @(posedge clk);
        #1;
    endtask

    function automatic int cur_pos();
        return t_run % SD;
    endfunction

    function automatic int cur_dig();
        return (t_run / SD) % ND;
    endfunction

    task automatic test_reset();
        rst = 1'b1; i_en = 1'b1; i_seg = '0; i_dp = '0; i_blank = '0; i_blink = '0; i_bright = '1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs !== {4'b1111, 7'h00, 1'b0, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: got %h expected %h", obs, {4'b1111, 7'h00, 1'b0, 2'd0, 1'b0});
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_full_scan();
        int ticks, last_tick;
        ticks = 0; last_tick = -1;
        i_en = 1'b1; i_bright = 3'd7; i_seg = {7'h7E, 7'h30, 7'h6D, 7'h79};
        for (int c = 1; c <= 96; c++) begin
            tick();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL full_scan cyc %0d: got %h expected %h", c, obs, exp_v);
            end
            if (c == 1) begin
                checks++;
                if ({o_seg_enb, o_seg} !== {4'b1110, 7'h79}) begin
                    errors++;
                    $display("FAIL first_digit0: got %b/%h expected 1110/79", o_seg_enb, o_seg);
                end
            end
            if (o_frame_tick === 1'b1) begin
                if (last_tick >= 0) begin
                    checks++;
                    if (c - last_tick != 32) begin
                        errors++;
                        $display("FAIL tick_interval: got %0d expected 32", c - last_tick);
                    end
                end
                last_tick = c;
                ticks++;
            end
        end
        checks++;
        if (ticks != 2) begin
            errors++;
            $display("FAIL tick_count: got %0d expected 2", ticks);
        end
    endtask

    task automatic test_dimming();
        int lit_cnt[4];
        for (int s = 0; s < 4; s++) lit_cnt[s] = 0;
        i_bright = 3'd1;
        for (int c = 0; c < 32; c++) begin
            if (c == 18) i_bright = 3'd3;
            tick();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL dimming cyc %0d: got %h expected %h", c, obs, exp_v);
            end
            if (o_seg_enb !== 4'b1111) lit_cnt[c / 8]++;
        end
        checks++;
        if (lit_cnt[1] != 2 || lit_cnt[2] != 2 || lit_cnt[3] != 4) begin
            errors++;
            $display("FAIL dim_lit_counts: got %0d/%0d/%0d expected 2/2/4", lit_cnt[1], lit_cnt[2], lit_cnt[3]);
        end
    endtask

    task automatic test_blink_blank();
        int d0, d1, d2;
        d0 = 0; d1 = 0; d2 = 0;
        i_bright = 3'd7; i_blink = 4'b0010; i_blank = 4'b0100;
        for (int c = 0; c < 300; c++) begin
            tick();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL blink_blank cyc %0d: got %h expected %h", c, obs, exp_v);
            end
            if (o_seg_enb[0] === 1'b0) d0++;
            if (o_seg_enb[1] === 1'b0) d1++;
            if (o_seg_enb[2] === 1'b0) d2++;
        end
        checks++;
        if (d2 != 0 || d1 == 0 || d1 >= d0) begin
            errors++;
            $display("FAIL blink_blank_counts: got d0=%0d d1=%0d d2=%0d expected d2=0, 0<d1<d0", d0, d1, d2);
        end
        i_blink = '0; i_blank = '0;
    endtask

    task automatic test_dp();
        int bad, on;
        bad = 0; on = 0;
        i_dp = 4'b1001;
        for (int c = 0; c < 64; c++) begin
            tick();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL dp cyc %0d: got %h expected %h", c, obs, exp_v);
            end
            if (o_seg_dp === 1'b1) begin
                on++;
                if (o_seg_enb !== 4'b1110 && o_seg_enb !== 4'b0111) bad++;
            end
        end
        checks++;
        if (bad != 0 || on == 0) begin
            errors++;
            $display("FAIL dp_placement: got bad=%0d on=%0d expected bad=0 on>0", bad, on);
        end
    endtask

    task automatic test_enable_drop();
        int n, d0;
        n = 0; d0 = 0;
        while (!(cur_dig() == 2 && cur_pos() == 3) && n < 64) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 64) begin
            errors++;
            $display("FAIL en_drop_seek: got timeout expected digit2 pcnt3");
        end
        i_en = 1'b0;
        tick();
        checks++;
        if ({o_seg_enb, o_digit_idx, o_seg} !== {4'b1111, 2'd0, 7'h00} || obs !== exp_v) begin
            errors++;
            $display("FAIL en_drop_dark: got %h expected %h", obs, exp_v);
        end
        repeat (3) tick();
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL en_off_hold: got %h expected %h", obs, exp_v);
        end
        i_en = 1'b1;
        for (int c = 0; c < 9; c++) begin
            tick();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL en_restart cyc %0d: got %h expected %h", c, obs, exp_v);
            end
            if (o_seg_enb === 4'b1110) d0++;
        end
        checks++;
        if (d0 != 8 || o_seg_enb !== 4'b1101) begin
            errors++;
            $display("FAIL en_restart_slot: got d0=%0d enb=%b expected 8/1101", d0, o_seg_enb);
        end
    endtask

    task automatic test_async_reset();
        int n;
        n = 0;
        while (!(cur_dig() == 3 && cur_pos() == 4) && n < 64) begin
            tick();
            n++;
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== {4'b1111, 7'h00, 1'b0, 2'd0, 1'b0} || n >= 64) begin
            errors++;
            $display("FAIL async_reset_now: got %h expected %h", obs, {4'b1111, 7'h00, 1'b0, 2'd0, 1'b0});
        end
        @(posedge clk);
        #1;
        checks++;
        if (obs !== {4'b1111, 7'h00, 1'b0, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset_hold: got %h expected %h", obs, {4'b1111, 7'h00, 1'b0, 2'd0, 1'b0});
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 40; c++) begin
            tick();
            checks++;
            if (obs !== exp_v || (c == 0 && o_seg_enb !== 4'b1110)) begin
                errors++;
                $display("FAIL post_reset cyc %0d: got %h expected %h", c, obs, exp_v);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            i_seg    = (ND*SW)'($urandom());
            i_dp     = ND'($urandom());
            i_blank  = ($urandom_range(0, 3) == 0) ? ND'($urandom()) : '0;
            i_blink  = ND'($urandom());
            if ($urandom_range(0, 7) == 0) i_bright = BW'($urandom());
            i_en     = ($urandom_range(0, 31) != 0);
            tick();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL random cyc %0d: got %h expected %h", c, obs, exp_v);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_full_scan();
        test_dimming();
        test_blink_blank();
        test_dp();
        test_enable_drop();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_scan_mux.md
# led_scan_mux

Parametrised multiplexed seven-segment display scanner. It is the next-generation display driver for the clock designs and replaces fixed six-digit scanning with a configurable digit count and slot length. It adds per-digit blanking, per-digit blinking for set-up mode indication, and PWM brightness control. It sits between the segment decoders and the board's common-node segment pins, and runs off the system clock with no derived clocks.

## Interface
- NUM_DIGITS, 6, number of multiplexed digits (≥2)
- SEG_W, 7, segment bits per digit ({a..g}, MSB = a)
- SCAN_DIV, 5000, clk cycles per digit slot (≥ 2**BRIGHT_W)
- BLINK_DIV, 25000000, clk cycles per blink half-period (≥2)
- BRIGHT_W, 3, brightness control width
- IDX_W, $clog2(NUM_DIGITS), digit index width (derived, not overridden)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- i_en  in  1  scan enable
- i_seg  in  NUM_DIGITS*SEG_W  digit d segments at [d*SEG_W +: SEG_W], active-high
- i_dp  in  NUM_DIGITS  decimal point per digit
- i_blank  in  NUM_DIGITS  1 = digit d forced dark
- i_blink  in  NUM_DIGITS  1 = digit d blinks
- i_bright  in  BRIGHT_W  brightness, 0 = dimmest, all-ones = full
- o_seg  out  SEG_W  active segments of current digit
- o_seg_dp  out  1  decimal point of current digit
- o_seg_enb  out  NUM_DIGITS  common-node enables, active-low, at most one bit low
- o_digit_idx  out  IDX_W  digit index currently driven
- o_frame_tick  out  1  one-cycle pulse at each frame start

## Operation
- **Prescaler `pcnt`.** Counts 0..SCAN_DIV-1 while i_en=1. At SCAN_DIV-1 it wraps to 0 and advances `idx`.
- **Digit index `idx`.** Runs 0..NUM_DIGITS-1, then wraps to 0. On the wrap NUM_DIGITS-1→0, o_frame_tick=1 for exactly one cycle.
- **Brightness.** `bright_q` captures i_bright when pcnt wraps; it is loaded with all-ones at reset.
  - on_cycles = ((bright_q+1)*SCAN_DIV) >> BRIGHT_W.
  - Intermediate product width: BRIGHT_W+1+$clog2(SCAN_DIV+1) bits, with no truncation before the shift.
  - The digit is lit only while pcnt < on_cycles.
  - All-ones brightness gives on_cycles = SCAN_DIV, i.e. lit for the whole slot.
- **Blink.** A free-running counter toggles `blink_ph` every BLINK_DIV cycles. It is independent of i_en and reset to 0.
- **Lit condition.** lit = i_en & (pcnt < on_cycles) & ~i_blank[idx] & ~(i_blink[idx] & blink_ph).
- **When lit:**
  - o_seg_enb has only bit idx low.
  - o_seg = i_seg slice for idx.
  - o_seg_dp = i_dp[idx].
- **When not lit:** o_seg_enb = all ones, o_seg = 0, o_seg_dp = 0.
- **o_digit_idx** tracks idx whether or not the digit is lit.
- **i_en=0.** pcnt and idx are held at 0 and outputs are dark. When i_en returns to 1, scanning restarts at digit 0 with pcnt=0.
- **Blank vs blink.** i_blank has priority over i_blink; both only darken.
- **Input changes.** i_seg, i_dp, i_blank and i_blink are used combinationally every cycle, so a change takes effect mid-slot. i_bright takes effect only at the next slot boundary.

## Timing
- **Registered outputs.** All outputs are registered. Outputs in cycle n+1 reflect the counter state and inputs of cycle n, giving 1-cycle latency.
- **Reset (asynchronous).** While rst=1 the outputs hold these values immediately:
  - o_seg_enb = all ones
  - o_seg = 0, o_seg_dp = 0
  - o_digit_idx = 0, o_frame_tick = 0
  - internally: pcnt = 0, idx = 0, blink_ph = 0, blink counter = 0, bright_q = all ones
- **Reset mid-slot.** The partial slot is abandoned and no frame_tick is emitted.
- **First frame after reset.** The first rising edge after rst falls, with i_en=1, begins digit 0 slot at pcnt=0. o_seg_enb[0] goes low one cycle later.
- **Slot and frame length.** Slot length is exactly SCAN_DIV cycles; frame length is NUM_DIGITS*SCAN_DIV cycles.
- **o_frame_tick timing.** It is asserted in the same output cycle as the first lit output of digit 0. That first output occurs NUM_DIGITS*SCAN_DIV cycles after the previous tick.
- **Blink period.** blink_ph toggles exactly every BLINK_DIV cycles.
- **Simultaneous events.**
  - A pcnt wrap coinciding with a blink toggle uses the new blink_ph from the next cycle.
  - i_en falling on a wrap cycle does not advance idx.

## Test plan
Bench parameters: NUM_DIGITS=4, SEG_W=7, SCAN_DIV=8, BLINK_DIV=64, BRIGHT_W=3.

- **Full-brightness scan.** Stimulus: i_bright=7, i_en=1, i_seg={7'h7E,7'h30,7'h6D,7'h79}. Response:
  - o_seg_enb steps 1110→1101→1011→0111, 8 cycles each.
  - o_seg shows 7'h79, 7'h6D, 7'h30, 7'h7E in turn.
  - o_frame_tick pulses once every 32 cycles.
- **Dimming.** Stimulus: i_bright=1. Response: on_cycles=2, so each digit is low 2 of 8 cycles and dark for 6. Changing i_bright to 3 mid-slot gives 4 cycles lit starting from the next slot only.
- **Blink and blank.** Stimulus: i_blink=4'b0010, i_blank=4'b0100. Response:
  - Digit 1 is lit in blink phase 0 and dark for the 64-cycle phase 1.
  - Digit 2 is never lit.
  - Digits 0 and 3 are unaffected.
- **Decimal point.** Stimulus: i_dp=4'b1001. Response: o_seg_dp=1 only during lit cycles of digits 0 and 3, and 0 whenever o_seg_enb is all ones.
- **Enable drop.** Stimulus: i_en 1→0 during digit 2 slot at pcnt=3. Response: outputs are dark the next cycle and o_digit_idx=0. On re-enable, digit 0 is lit one cycle later with a fresh 8-cycle slot.
- **Asynchronous reset.** Stimulus: rst pulsed high mid-slot of digit 3, between clock edges. Response: o_seg_enb=1111, o_seg=0 and o_digit_idx=0 immediately, with no frame_tick. After release, the scan restarts at digit 0.
